// File: rtl/tpm_txn_sequencer.sv
// rtl/tpm_txn_sequencer.sv - sequences init pulses to the MAIN and PRIV AXI masters and collects status
module tpm_txn_sequencer #(
  parameter int INIT_PULSE_CYCLES = 2,
  parameter int TMO_W             = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             start,
  input  logic [1:0]       port_en,
  input  logic [TMO_W-1:0] timeout_cycles,
  output logic             TPM_TO_MAIN_INIT_AXI_TXN,
  input  logic             TPM_TO_MAIN_TXN_DONE,
  input  logic             TPM_TO_MAIN_ERROR,
  output logic             TPM_TO_PRIV_INIT_AXI_TXN,
  input  logic             TPM_TO_PRIV_TXN_DONE,
  input  logic             TPM_TO_PRIV_ERROR,
  output logic             busy,
  output logic             seq_done,
  output logic [3:0]       status
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MAIN_INIT = 3'd1,
    MAIN_WAIT = 3'd2,
    PRIV_INIT = 3'd3,
    PRIV_WAIT = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [3:0]       PULSE_LAST = 4'(INIT_PULSE_CYCLES - 1);
  localparam logic [TMO_W-1:0] WCNT_MAX   = {TMO_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       en_q;
  logic [TMO_W-1:0] tmo_q;
  logic [3:0]       pcnt;
  logic [TMO_W-1:0] wcnt;
  logic             main_done_q;
  logic             priv_done_q;
  logic             hit_q;

  logic main_edge;
  logic priv_edge;
  logic in_main;
  logic in_init;
  logic in_wait;
  logic cur_edge;
  logic pulse_last;
  logic tmo_hit;
  logic wait_exit;
  logic start_ok;

  // done edges are taken against the registered level so a level already high at entry never counts
  assign main_edge  = TPM_TO_MAIN_TXN_DONE & ~main_done_q;
  assign priv_edge  = TPM_TO_PRIV_TXN_DONE & ~priv_done_q;
  assign in_main    = (state == MAIN_INIT) || (state == MAIN_WAIT);
  assign in_init    = (state == MAIN_INIT) || (state == PRIV_INIT);
  assign in_wait    = (state == MAIN_WAIT) || (state == PRIV_WAIT);
  assign cur_edge   = in_main ? main_edge : priv_edge;
  assign pulse_last = (pcnt == PULSE_LAST);
  assign tmo_hit    = (tmo_q != '0) && (wcnt == tmo_q - TMO_W'(1));
  // an edge seen during the pulse (hit_q) completes in the first wait cycle
  assign wait_exit  = hit_q | cur_edge | tmo_hit;
  assign start_ok   = (state == IDLE) && start;

  // state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (port_en == 2'b00) state_nxt = DONE;
          else if (port_en[0])  state_nxt = MAIN_INIT;
          else                  state_nxt = PRIV_INIT;
        end
      end
      MAIN_INIT: if (pulse_last) state_nxt = MAIN_WAIT;
      MAIN_WAIT: if (wait_exit)  state_nxt = en_q[1] ? PRIV_INIT : DONE;
      PRIV_INIT: if (pulse_last) state_nxt = PRIV_WAIT;
      PRIV_WAIT: if (wait_exit)  state_nxt = DONE;
      DONE:                      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // latched request, pulse/wait counters, done copies and pending-completion flag
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_q        <= 2'b00;
      tmo_q       <= '0;
      pcnt        <= 4'd0;
      wcnt        <= '0;
      main_done_q <= 1'b0;
      priv_done_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      main_done_q <= TPM_TO_MAIN_TXN_DONE;
      priv_done_q <= TPM_TO_PRIV_TXN_DONE;
      if (start_ok) begin
        en_q  <= port_en;
        tmo_q <= timeout_cycles;
      end
      if (in_init && !pulse_last) pcnt <= pcnt + 4'd1;
      else                        pcnt <= 4'd0;
      if (in_wait && (state_nxt == state)) begin
        if (wcnt != WCNT_MAX) wcnt <= wcnt + TMO_W'(1);
      end else begin
        wcnt <= '0;
      end
      hit_q <= in_init & (hit_q | cur_edge);
    end
  end

  // status capture: error at the done edge, timeout only when no completion in that cycle
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      status <= 4'b0000;
    end else if (start_ok) begin
      status <= 4'b0000;
    end else begin
      case (state)
        MAIN_INIT: if (main_edge) status[0] <= TPM_TO_MAIN_ERROR;
        MAIN_WAIT: begin
          if (main_edge)                status[0] <= TPM_TO_MAIN_ERROR;
          else if (!hit_q && tmo_hit)   status[1] <= 1'b1;
        end
        PRIV_INIT: if (priv_edge) status[2] <= TPM_TO_PRIV_ERROR;
        PRIV_WAIT: begin
          if (priv_edge)                status[2] <= TPM_TO_PRIV_ERROR;
          else if (!hit_q && tmo_hit)   status[3] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // registered outputs aligned with the state they belong to
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      TPM_TO_MAIN_INIT_AXI_TXN <= 1'b0;
      TPM_TO_PRIV_INIT_AXI_TXN <= 1'b0;
      busy                     <= 1'b0;
      seq_done                 <= 1'b0;
    end else begin
      TPM_TO_MAIN_INIT_AXI_TXN <= (state_nxt == MAIN_INIT);
      TPM_TO_PRIV_INIT_AXI_TXN <= (state_nxt == PRIV_INIT);
      busy                     <= (state_nxt == MAIN_INIT) || (state_nxt == MAIN_WAIT) ||
                                  (state_nxt == PRIV_INIT) || (state_nxt == PRIV_WAIT);
      seq_done                 <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_tpm_txn_sequencer.sv
// tb/tb_tpm_txn_sequencer.sv - randomized bench for tpm_txn_sequencer against a cycle-count reference model
module tb_tpm_txn_sequencer;

  localparam int P  = 2;
  localparam int TW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    port_en = 2'b00;
  logic [TW-1:0] timeout_cycles = '0;
  logic          main_init;
  logic          main_done = 1'b0;
  logic          main_error = 1'b0;
  logic          priv_init;
  logic          priv_done = 1'b0;
  logic          priv_error = 1'b0;
  logic          busy;
  logic          seq_done;
  logic [3:0]    status;

  int total = 0;
  int bad   = 0;

  tpm_txn_sequencer #(.INIT_PULSE_CYCLES(P), .TMO_W(TW)) dut (
    .ACLK                     (aclk),
    .ARESETN                  (aresetn),
    .start                    (start),
    .port_en                  (port_en),
    .timeout_cycles           (timeout_cycles),
    .TPM_TO_MAIN_INIT_AXI_TXN (main_init),
    .TPM_TO_MAIN_TXN_DONE     (main_done),
    .TPM_TO_MAIN_ERROR        (main_error),
    .TPM_TO_PRIV_INIT_AXI_TXN (priv_init),
    .TPM_TO_PRIV_TXN_DONE     (priv_done),
    .TPM_TO_PRIV_ERROR        (priv_error),
    .busy                     (busy),
    .seq_done                 (seq_done),
    .status                   (status)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One port phase: pulse of P cycles, then wait cycles until the done edge or the timeout.
  // d = done-edge cycle relative to pulse start (-1 = never).
  function automatic void phase_model(input int d, input bit e, input int t,
                                      output int len, output bit err_o, output bit tmo_o);
    int w;
    w = (d < 0) ? 32'h4000_0000 : ((d > P) ? d - P : 0);
    if (t != 0 && w > t - 1) begin
      w = t - 1; tmo_o = 1'b1; err_o = 1'b0;
    end else begin
      tmo_o = 1'b0; err_o = e;
    end
    len = P + w + 1;
  endfunction

  task automatic run_seq(input logic [1:0] en, input int t, input int dm, input int dp,
                         input bit em, input bit ep, input bit stale, input bit stray);
    int m_at = -100, p_at = -100, sd_at, cur, len, end_c;
    bit me = 0, mt = 0, pe = 0, pt = 0;
    logic [3:0] exp_st;
    int m_hi = 0, p_hi = 0, m_rise = -1, p_rise = -1, sd_n = 0, sd_c = -1;
    logic [3:0] st_sd = 4'hf;
    logic busy_sd = 1'b1, busy1 = 1'b0;
    bit m_win, p_win;
    cur = 1;
    if (en[0]) begin m_at = cur; phase_model(dm, em, t, len, me, mt); cur += len; end
    if (en[1]) begin p_at = cur; phase_model(dp, ep, t, len, pe, pt); cur += len; end
    sd_at  = (en == 2'b00) ? 2 : cur + 1;
    exp_st = {pt, pe, mt, me};
    end_c  = sd_at + 3;
    if (en[0] && dm >= 0 && m_at + dm + 6 > end_c) end_c = m_at + dm + 6;
    if (en[1] && dp >= 0 && p_at + dp + 6 > end_c) end_c = p_at + dp + 6;
    if (end_c > 3000) end_c = 3000;
    for (int c = -3; c <= end_c; c++) begin
      @(negedge aclk);
      if (main_init) begin m_hi++; if (m_rise < 0) m_rise = c; end
      if (priv_init) begin p_hi++; if (p_rise < 0) p_rise = c; end
      if (seq_done) begin sd_n++; sd_c = c; st_sd = status; busy_sd = busy; end
      if (c == 1) busy1 = busy;
      start          = (c == 0) || (stray && c == 2);
      port_en        = (stray && c == 2) ? 2'($urandom_range(0, 3)) : en;
      timeout_cycles = TW'(t);
      m_win      = en[0] && dm >= 0 && c >= m_at + dm && c <= m_at + dm + 2;
      p_win      = en[1] && dp >= 0 && c >= p_at + dp && c <= p_at + dp + 2;
      main_done  = (stale && c <= m_at) || m_win;
      main_error = em && m_win;
      priv_done  = p_win;
      priv_error = ep && p_win;
    end
    start = 1'b0;
    chk("main_pulse_len", m_hi, en[0] ? P : 0);
    chk("priv_pulse_len", p_hi, en[1] ? P : 0);
    if (en[0]) chk("main_pulse_at", m_rise, m_at);
    if (en[1]) chk("priv_pulse_at", p_rise, p_at);
    chk("seq_done_count", sd_n, 1);
    chk("seq_done_at", sd_c, sd_at);
    chk("status_at_done", st_sd, exp_st);
    chk("busy_at_done", busy_sd, 0);
    chk("busy_after_start", busy1, en != 2'b00);
    chk("status_hold", status, exp_st);
  endtask

  initial begin
    int m_hi, p_hi, sd_n;
    repeat (3) @(negedge aclk);
    chk("reset_main_init", main_init, 0);
    chk("reset_priv_init", priv_init, 0);
    chk("reset_busy", busy, 0);
    chk("reset_seq_done", seq_done, 0);
    chk("reset_status", status, 0);
    aresetn = 1'b1;

    run_seq(2'b11, 0, 10, 12, 0, 0, 0, 0);
    run_seq(2'b01, 0, 7, 0, 1, 0, 0, 0);
    run_seq(2'b11, 50, -1, 6, 0, 0, 0, 0);
    run_seq(2'b01, 0, 5, 0, 0, 0, 1, 0);
    run_seq(2'b11, 0, 4, 3, 0, 1, 0, 1);
    run_seq(2'b00, 0, 0, 0, 0, 0, 0, 0);
    run_seq(2'b11, 3, 4, 5, 1, 0, 0, 0);
    run_seq(2'b10, 0, 0, 1, 0, 1, 0, 0);
    run_seq(2'b11, 0, 1, 2, 1, 1, 0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] en;
      int t, dm, dp;
      bit stale, stray;
      en = 2'($urandom_range(0, 3));
      t  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 25));
      dm = int'($urandom_range(0, 30));
      dp = int'($urandom_range(0, 30));
      if (t != 0 && $urandom_range(0, 4) == 0) dm = -1;
      if (t != 0 && $urandom_range(0, 4) == 0) dp = -1;
      stale = en[0] && ($urandom_range(0, 3) == 0);
      if (stale && dm >= 0 && dm < 2) dm = 2;
      stray = (en != 2'b00) && ($urandom_range(0, 2) == 0);
      run_seq(en, t, dm, dp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), stale, stray);
    end

    @(negedge aclk);
    port_en = 2'b11; timeout_cycles = '0; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    chk("rst_pulse_active", main_init, 1);
    #1 aresetn = 1'b0;
    #1;
    chk("rst_main_init", main_init, 0);
    chk("rst_priv_init", priv_init, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_status", status, 0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    m_hi = 0; p_hi = 0; sd_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      if (main_init) m_hi++;
      if (priv_init) p_hi++;
      if (seq_done)  sd_n++;
      if (c == 5)  begin main_done = 1'b1; priv_done = 1'b1; end
      if (c == 10) begin main_done = 1'b0; priv_done = 1'b0; end
    end
    chk("post_rst_main_pulses", m_hi, 0);
    chk("post_rst_priv_pulses", p_hi, 0);
    chk("post_rst_seq_done", sd_n, 0);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
